// File: rtl/register_file_dp.sv
// Dual-read-port UART-system register file: per-register reset values, config-region write lock,
// out-of-range flagging and a flat config bus. Optional macro RF_SHADOW_EN adds commit-loaded shadow registers.
module register_file_dp #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int DEPTH      = 16,
    parameter int CFG_REGS   = 4,
    parameter logic [DEPTH*DATA_WIDTH-1:0] RST_VALUE =
        128'h0000_0000_0000_0000_0000_0000_081C_0000
) (
    input  logic                           RF_CLK,
    input  logic                           RF_RST,
    input  logic                           RF_Wr_en,
    input  logic [ADDR_WIDTH-1:0]          RF_Addr,
    input  logic [DATA_WIDTH-1:0]          RF_WrData,
    input  logic                           RF_Rd_en,
    output logic [DATA_WIDTH-1:0]          RF_RdData,
    output logic                           RF_Rd_Data_Valid,
    input  logic                           RF_Rd_en_B,
    input  logic [ADDR_WIDTH-1:0]          RF_Addr_B,
    output logic [DATA_WIDTH-1:0]          RF_RdData_B,
    output logic                           RF_Rd_Data_Valid_B,
    input  logic                           RF_Lock,
    input  logic                           RF_Commit,
    output logic [CFG_REGS*DATA_WIDTH-1:0] RF_Cfg_Regs,
    output logic                           RF_Addr_Err,
    output logic                           RF_Wr_Blocked
);

    // One extra bit so the limit compare stays correct when DEPTH == 2**ADDR_WIDTH.
    localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] CFG_LIM   = (ADDR_WIDTH+1)'(CFG_REGS);

    logic [DATA_WIDTH-1:0] regs [DEPTH];
    logic [DATA_WIDTH-1:0] rd_a_word;
    logic [DATA_WIDTH-1:0] rd_b_word;
    logic                  a_oor;
    logic                  b_oor;
    logic                  a_cfg;
    logic                  wr_ok;
    logic                  wr_blk;

    assign a_oor  = {1'b0, RF_Addr}   >= DEPTH_LIM;
    assign b_oor  = {1'b0, RF_Addr_B} >= DEPTH_LIM;
    assign a_cfg  = {1'b0, RF_Addr}   <  CFG_LIM;
    assign wr_blk = RF_Wr_en && !a_oor && RF_Lock && a_cfg;
    assign wr_ok  = RF_Wr_en && !a_oor && !(RF_Lock && a_cfg);

    // NOTE: this storage is reset on purpose -- each register has a defined power-up value that the UART relies on.
    always_ff @(posedge RF_CLK or negedge RF_RST) begin
        if (!RF_RST) begin
            for (int i = 0; i < DEPTH; i++)
                regs[i] <= RST_VALUE[i*DATA_WIDTH +: DATA_WIDTH];
        end else begin
            for (int i = 0; i < DEPTH; i++)
                if (wr_ok && RF_Addr == ADDR_WIDTH'(i))
                    regs[i] <= RF_WrData;
        end
    end

    // NOTE: defaults first keep this mux latch-free; out-of-range addresses fall through to zero.
    always_comb begin
        rd_a_word = '0;
        rd_b_word = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (RF_Addr   == ADDR_WIDTH'(i)) rd_a_word = regs[i];
            if (RF_Addr_B == ADDR_WIDTH'(i)) rd_b_word = regs[i];
        end
        if (wr_ok)                          rd_a_word = RF_WrData;
        if (wr_ok && RF_Addr_B == RF_Addr)  rd_b_word = RF_WrData;
    end

    always_ff @(posedge RF_CLK or negedge RF_RST) begin
        if (!RF_RST) begin
            RF_RdData          <= '0;
            RF_Rd_Data_Valid   <= 1'b0;
            RF_RdData_B        <= '0;
            RF_Rd_Data_Valid_B <= 1'b0;
            RF_Addr_Err        <= 1'b0;
            RF_Wr_Blocked      <= 1'b0;
        end else begin
            RF_Rd_Data_Valid   <= RF_Rd_en;
            RF_Rd_Data_Valid_B <= RF_Rd_en_B;
            if (RF_Rd_en)   RF_RdData   <= rd_a_word;
            if (RF_Rd_en_B) RF_RdData_B <= rd_b_word;
            RF_Addr_Err   <= ((RF_Wr_en || RF_Rd_en) && a_oor) || (RF_Rd_en_B && b_oor);
            RF_Wr_Blocked <= wr_blk;
        end
    end

`ifdef RF_SHADOW_EN
    logic [DATA_WIDTH-1:0] shadow [CFG_REGS];

    // Commit samples pre-write contents, so a same-edge write lands in the next commit.
    always_ff @(posedge RF_CLK or negedge RF_RST) begin
        if (!RF_RST) begin
            for (int i = 0; i < CFG_REGS; i++)
                shadow[i] <= RST_VALUE[i*DATA_WIDTH +: DATA_WIDTH];
        end else if (RF_Commit) begin
            for (int i = 0; i < CFG_REGS; i++)
                shadow[i] <= regs[i];
        end
    end

    for (genvar g = 0; g < CFG_REGS; g++) begin : g_cfg
        assign RF_Cfg_Regs[g*DATA_WIDTH +: DATA_WIDTH] = shadow[g];
    end
`else
    logic unused_commit;
    assign unused_commit = RF_Commit;

    for (genvar g = 0; g < CFG_REGS; g++) begin : g_cfg
        assign RF_Cfg_Regs[g*DATA_WIDTH +: DATA_WIDTH] = regs[g];
    end
`endif

endmodule
